// File: rtl/pixel_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pixel_receiver: 160x120x3 framebuffer with plot port and raster readout.     |
// | Optional power-up white fill: PIXEL_RECEIVER_CLEAR_EN.  Revision: 1.0        |
// +----------------------------------------------------------------------------+
module pixel_receiver (
  input  logic       iClock,
  input  logic       iReset,
  input  logic [7:0] iX,
  input  logic [6:0] iY,
  input  logic [2:0] iColour,
  input  logic       iPlot,
  input  logic       iStartScan,
  output logic       oBusy,
  output logic [7:0] oX,
  output logic [6:0] oY,
  output logic [2:0] oColour,
  output logic       oValid,
  output logic       oDone,
  output logic [7:0] oDropCount
);

  localparam int         c_DEPTH  = 19200;
  localparam logic [7:0] c_WIDTH  = 8'd160;
  localparam logic [6:0] c_HEIGHT = 7'd120;
  localparam logic [7:0] c_XMAX   = 8'd159;
  localparam logic [6:0] c_YMAX   = 7'd119;
  localparam logic [2:0] c_BG     = 3'd7;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    SCAN  = 2'd2,
    FLUSH = 2'd3
  } state_t;

`ifdef PIXEL_RECEIVER_CLEAR_EN
  localparam state_t c_RESET_STATE = CLEAR;
`else
  localparam state_t c_RESET_STATE = IDLE;
`endif

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_fb [0:c_DEPTH-1];
  logic [7:0]  r_x;
  logic [6:0]  r_y;
  logic [7:0]  r_ox;
  logic [6:0]  r_oy;
  logic [2:0]  r_colour;
  logic        r_valid;
  logic        r_done;
  logic [7:0]  r_drops;

  logic        w_clearing;
  logic        w_last;
  logic        w_step;
  logic        w_in_range;
  logic        w_we;
  logic        w_drop;
  logic [14:0] w_raddr;
  logic [14:0] w_waddr;
  logic [2:0]  w_wdata;

  function automatic logic [14:0] lin_addr(input logic [7:0] x, input logic [6:0] y);
    return ({8'd0, y} * 15'd160) + {7'd0, x};
  endfunction

`ifdef PIXEL_RECEIVER_CLEAR_EN
  assign w_clearing = (r_state == CLEAR);
`else
  assign w_clearing = 1'b0;
`endif

  // The scan counters double as the fill address while clearing.
  assign w_last     = (r_x == c_XMAX) && (r_y == c_YMAX);
  assign w_step     = (r_state == SCAN) || w_clearing;
  assign w_raddr    = lin_addr(r_x, r_y);
  assign w_in_range = (iX < c_WIDTH) && (iY < c_HEIGHT);
  assign w_we       = !iReset && (w_clearing || (iPlot && w_in_range));
  assign w_waddr    = w_clearing ? w_raddr : lin_addr(iX, iY);
  assign w_wdata    = w_clearing ? c_BG : iColour;
  assign w_drop     = !iReset && !w_clearing && iPlot && !w_in_range;

  always_comb begin
    w_next = r_state;
    oBusy  = (r_state != IDLE);
    case (r_state)
      CLEAR:   if (!w_clearing || w_last) w_next = IDLE;
      IDLE:    if (iStartScan) w_next = SCAN;
      SCAN:    if (w_last) w_next = FLUSH;
      FLUSH:   w_next = IDLE;
      default: w_next = c_RESET_STATE;
    endcase
  end

  // Framebuffer contents survive reset; only writes are blocked.
  always_ff @(posedge iClock) begin
    if (w_we) r_fb[w_waddr] <= w_wdata;
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_x <= 8'd0;
      r_y <= 7'd0;
    end else if (w_step) begin
      if (r_x == c_XMAX) begin
        r_x <= 8'd0;
        r_y <= (r_y == c_YMAX) ? 7'd0 : r_y + 7'd1;
      end else begin
        r_x <= r_x + 8'd1;
      end
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state  <= c_RESET_STATE;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_ox     <= 8'd0;
      r_oy     <= 7'd0;
      r_colour <= 3'd0;
      r_drops  <= 8'd0;
    end else begin
      r_state <= w_next;
      r_valid <= (r_state == SCAN);
      r_done  <= (r_state == SCAN) && w_last;
      // Read ahead of the same-edge write, so a colliding plot yields old data.
      if (r_state == SCAN) begin
        r_ox     <= r_x;
        r_oy     <= r_y;
        r_colour <= r_fb[w_raddr];
      end
      if (w_drop && (r_drops != 8'hFF)) r_drops <= r_drops + 8'd1;
    end
  end

  assign oX         = r_ox;
  assign oY         = r_oy;
  assign oColour    = r_colour;
  assign oValid     = r_valid;
  assign oDone      = r_done;
  assign oDropCount = r_drops;

endmodule
`default_nettype wire

// File: tb/tb_pixel_receiver.sv
`default_nettype none
// Bench for pixel_receiver: directed scans plus random plots against an
// array model of the framebuffer; honours PIXEL_RECEIVER_CLEAR_EN.
module tb_pixel_receiver;

  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;
`ifdef PIXEL_RECEIVER_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic       iClock     = 1'b0;
  logic       iReset     = 1'b1;
  logic [7:0] iX         = 8'd0;
  logic [6:0] iY         = 7'd0;
  logic [2:0] iColour    = 3'd0;
  logic       iPlot      = 1'b0;
  logic       iStartScan = 1'b0;
  logic       oBusy;
  logic [7:0] oX;
  logic [6:0] oY;
  logic [2:0] oColour;
  logic       oValid;
  logic       oDone;
  logic [7:0] oDropCount;

  int errors = 0;
  int checks = 0;
  int drops  = 0;
  int model [N];
  bit known [N];
  int exp_c [N];
  bit exp_k [N];
  int obs_c [N];

  always #10 iClock = ~iClock;

  pixel_receiver dut (
    .iClock     (iClock),
    .iReset     (iReset),
    .iX         (iX),
    .iY         (iY),
    .iColour    (iColour),
    .iPlot      (iPlot),
    .iStartScan (iStartScan),
    .oBusy      (oBusy),
    .oX         (oX),
    .oY         (oY),
    .oColour    (oColour),
    .oValid     (oValid),
    .oDone      (oDone),
    .oDropCount (oDropCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  task automatic fill_background();
    for (int i = 0; i < N; i++) begin
      model[i] = 7;
      known[i] = 1'b1;
    end
  endtask

  task automatic model_plot(input int x, input int y, input int c);
    if (x < W && y < H) begin
      model[y * W + x] = c;
      known[y * W + x] = 1'b1;
    end else if (drops < 255) begin
      drops++;
    end
  endtask

  task automatic plot(input int x, input int y, input int c);
    iX = 8'(x); iY = 7'(y); iColour = 3'(c); iPlot = 1'b1;
    tick();
    iPlot = 1'b0;
    model_plot(x, y, c);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (oBusy === 1'b1 && n < 30000) begin
      tick();
      n++;
    end
    check({tag, "_idle_timeout"}, 32'(n < 30000), 32'd1);
  endtask

  // Cycle c after the start edge issues pixel c; its data is expected on cycle c+1.
  task automatic run_scan(input int plot_at, input int px, input int py, input int pc,
                          input int start_at, input int reset_at, input string tag);
    int verr, kerr, cerr, dcnt, derr, berr, vcnt, xerr, p;
    bit aborted;
    verr = 0; kerr = 0; cerr = 0; dcnt = 0; derr = 0; berr = 0; vcnt = 0; xerr = 0;
    aborted = 1'b0;
    iStartScan = 1'b1;
    tick();
    iStartScan = 1'b0;
    for (int c = 0; c <= N + 3; c++) begin
      if (aborted && c > reset_at + 3) break;
      if (c < N && !aborted) begin
        exp_c[c] = model[c];
        exp_k[c] = known[c];
      end
      if (c == plot_at) begin
        iX = 8'(px); iY = 7'(py); iColour = 3'(pc); iPlot = 1'b1;
      end
      if (c == start_at) iStartScan = 1'b1;
      if (c == reset_at) iReset = 1'b1;
      @(negedge iClock);
      if (!aborted && c >= 1 && c <= N) begin
        p = c - 1;
        if (oValid !== 1'b1) verr++; else vcnt++;
        if (oX !== 8'(p % W) || oY !== 7'(p / W)) kerr++;
        obs_c[p] = int'(oColour);
        if (exp_k[p] && oColour !== 3'(exp_c[p])) cerr++;
        if (oDone === 1'b1) begin
          dcnt++;
          if (p != N - 1) derr++;
        end
        if (oBusy !== 1'b1) berr++;
      end else begin
        if (oValid !== 1'b0) xerr++;
        if (oDone !== 1'b0) begin
          dcnt++;
          derr++;
        end
        if (!aborted && c == 0 && oBusy !== 1'b1) berr++;
        if (!aborted && c > N && oBusy !== 1'b0) berr++;
        if (aborted && c == reset_at + 1) begin
          check({tag, "_rst_x"}, 32'(oX), 32'd0);
          check({tag, "_rst_y"}, 32'(oY), 32'd0);
          check({tag, "_rst_colour"}, 32'(oColour), 32'd0);
          check({tag, "_rst_drops"}, 32'(oDropCount), 32'd0);
          check({tag, "_rst_busy"}, 32'(oBusy), 32'(CLEAR_EN));
        end
      end
      @(posedge iClock);
      #1;
      if (c == plot_at) begin
        iPlot = 1'b0;
        model_plot(px, py, pc);
      end
      iStartScan = 1'b0;
      if (c == reset_at) begin
        iReset  = 1'b0;
        aborted = 1'b1;
        drops   = 0;
      end
    end
    check({tag, "_valid_gaps"}, 32'(verr), 32'd0);
    check({tag, "_coord_err"}, 32'(kerr), 32'd0);
    check({tag, "_colour_err"}, 32'(cerr), 32'd0);
    check({tag, "_stray_valid"}, 32'(xerr), 32'd0);
    check({tag, "_done_pos_err"}, 32'(derr), 32'd0);
    if (aborted) begin
      check({tag, "_done_after_abort"}, 32'(dcnt), 32'd0);
    end else begin
      check({tag, "_valid_count"}, 32'(vcnt), 32'(N));
      check({tag, "_done_count"}, 32'(dcnt), 32'd1);
      check({tag, "_busy_err"}, 32'(berr), 32'd0);
    end
  endtask

  initial begin
    int x, y;

    iReset = 1'b1;
    tick();
    check("rst_valid", 32'(oValid), 32'd0);
    check("rst_done", 32'(oDone), 32'd0);
    check("rst_x", 32'(oX), 32'd0);
    check("rst_y", 32'(oY), 32'd0);
    check("rst_colour", 32'(oColour), 32'd0);
    check("rst_drops", 32'(oDropCount), 32'd0);
    check("rst_busy", 32'(oBusy), 32'(CLEAR_EN));
    tick();
    iReset = 1'b0;
    for (int i = 0; i < N; i++) known[i] = 1'b0;

`ifdef PIXEL_RECEIVER_CLEAR_EN
    begin
      int n;
      n = 0;
      iX = 8'd10; iY = 7'd10; iColour = 3'd1; iPlot = 1'b1;
      while (n < N + 100) begin
        @(negedge iClock);
        if (oBusy !== 1'b1) break;
        n++;
        @(posedge iClock);
        #1;
        iPlot = 1'b0;
      end
      @(posedge iClock);
      #1;
      iPlot = 1'b0;
      check("clear_busy_cycles", 32'(n), 32'(N));
      check("clear_drops", 32'(oDropCount), 32'd0);
      fill_background();
    end
`else
    check("idle_busy_after_reset", 32'(oBusy), 32'd0);
`endif

    repeat (40) begin
      x = int'($urandom_range(W - 1, 0));
      y = int'($urandom_range(H - 1, 0));
      if (x == 10 && y == 10) x = 11;
      plot(x, y, int'($urandom_range(7, 0)));
    end
    plot(0, 0, 4);
    plot(159, 119, 5);
    plot(75, 55, 2);
    plot(100, 60, 6);

    plot(160, 0, 1);
    check("drop_first", 32'(oDropCount), 32'd1);
    plot(0, 120, 1);
    check("drop_second", 32'(oDropCount), 32'd2);
    repeat (300) begin
      if ($urandom_range(1, 0) == 1) begin
        x = int'($urandom_range(255, W));
        y = int'($urandom_range(127, 0));
      end else begin
        x = int'($urandom_range(W - 1, 0));
        y = int'($urandom_range(127, H));
      end
      plot(x, y, int'($urandom_range(7, 0)));
    end
    check("drop_saturate", 32'(oDropCount), 32'd255);
    check("drop_model", 32'(oDropCount), 32'(drops));

    run_scan(60 * W + 100, 100, 60, 3, 5000, -1, "scan1");
    check("scan1_pix_0_0", 32'(obs_c[0]), 32'd4);
    check("scan1_pix_159_119", 32'(obs_c[N - 1]), 32'd5);
    check("scan1_pix_75_55", 32'(obs_c[55 * W + 75]), 32'd2);
    check("scan1_collide_old", 32'(obs_c[60 * W + 100]), 32'd6);
`ifdef PIXEL_RECEIVER_CLEAR_EN
    check("scan1_pix_10_10_bg", 32'(obs_c[10 * W + 10]), 32'd7);
`endif

    run_scan(-1, 0, 0, 0, -1, -1, "scan2");
    check("scan2_collide_new", 32'(obs_c[60 * W + 100]), 32'd3);

    run_scan(-1, 0, 0, 0, -1, 8000, "abort");
`ifdef PIXEL_RECEIVER_CLEAR_EN
    wait_idle("abort_clear");
    fill_background();
`endif

    run_scan(-1, 0, 0, 0, -1, 50, "fresh");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
